// File: rtl/alu_pkg.sv
// Shared ALU function codes, MUL/DIV sequencer state encoding and datapath defaults.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALUFN_ADD = 4'h0;
  localparam logic [3:0] ALUFN_SUB = 4'h1;
  localparam logic [3:0] ALUFN_MUL = 4'h2;
  localparam logic [3:0] ALUFN_DIV = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NEGA = 3'd1,
    ST_NEGB = 3'd2,
    ST_ITER = 3'd3,
    ST_NEGQ = 3'd4,
    ST_DONE = 3'd5
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// EX-stage MUL/DIV sequencer: stalls the pipe and reuses the shared ALU for
// shift-add multiply and signed restoring divide; other ops pass straight through.
module alu_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [3:0]       ex_alufn,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fn,
  input  logic [WIDTH-1:0] alu_y,
  output logic             stall,
  output logic [WIDTH-1:0] ex_y,
  output logic             res_valid
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;

  logic             md_req;
  logic [WIDTH-1:0] r_shift;
  logic             ge;

  assign md_req = ex_valid & ~flush &
                  ((ex_alufn == ALUFN_MUL) | (ex_alufn == ALUFN_DIV));

  // Divide step: acc is the partial remainder R, mplier the dividend/quotient Q,
  // mcand the divisor magnitude D.  R' cannot overflow since R < D <= 2^(W-1).
  assign r_shift = {acc_q[WIDTH-2:0], mplier_q[WIDTH-1]};
  assign ge      = (r_shift >= mcand_q);

  // Next-state, register updates and shared-ALU steering.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    alu_a    = ex_a;
    alu_b    = ex_b;
    alu_fn   = ex_alufn;

    case (state_q)
      ST_IDLE: begin
        if (md_req) begin
          if (ex_alufn == ALUFN_MUL) begin
            acc_d    = '0;
            mcand_d  = ex_a;
            mplier_d = ex_b;
            cnt_d    = CNT_W'(WIDTH);
            op_d     = OP_MUL;
            state_d  = ST_ITER;
          end else if (ex_b == '0) begin
            res_d   = '1;
            op_d    = OP_DIV;
            state_d = ST_DONE;
          end else begin
            mplier_d = ex_a;
            mcand_d  = ex_b;
            qneg_d   = ex_a[WIDTH-1] ^ ex_b[WIDTH-1];
            acc_d    = '0;
            op_d     = OP_DIV;
            state_d  = ST_NEGA;
          end
        end
      end

      ST_NEGA: begin
        alu_a  = '0;
        alu_b  = mplier_q;
        alu_fn = ALUFN_SUB;
        if (mplier_q[WIDTH-1]) begin
          mplier_d = alu_y;
        end
        state_d = ST_NEGB;
      end

      ST_NEGB: begin
        alu_a  = '0;
        alu_b  = mcand_q;
        alu_fn = ALUFN_SUB;
        if (mcand_q[WIDTH-1]) begin
          mcand_d = alu_y;
        end
        cnt_d   = CNT_W'(WIDTH);
        state_d = ST_ITER;
      end

      ST_ITER: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          alu_a    = acc_q;
          alu_b    = mcand_q;
          alu_fn   = ALUFN_ADD;
          acc_d    = mplier_q[0] ? alu_y : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_W'(1)) begin
            res_d   = mplier_q[0] ? alu_y : acc_q;
            state_d = ST_DONE;
          end
        end else begin
          alu_a    = r_shift;
          alu_b    = mcand_q;
          alu_fn   = ALUFN_SUB;
          acc_d    = ge ? alu_y : r_shift;
          mplier_d = {mplier_q[WIDTH-2:0], ge};
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_NEGQ;
          end
        end
      end

      ST_NEGQ: begin
        alu_a   = '0;
        alu_b   = mplier_q;
        alu_fn  = ALUFN_SUB;
        res_d   = qneg_q ? alu_y : mplier_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
    end
  end

  // Flush kills both the stall and any pending result in the same cycle.
  assign stall     = ~flush & (((state_q == ST_IDLE) & md_req) |
                               ((state_q != ST_IDLE) & (state_q != ST_DONE)));
  assign res_valid = ~flush & (state_q == ST_DONE);
  assign ex_y      = res_valid ? res_q : alu_y;

endmodule

// File: doc/alu_muldiv_sequencer.md
# alu_muldiv_sequencer

Multi-cycle MUL/DIV sequencer for the EX stage of the pipelined Beta CPU. It detects MUL and DIV instructions (`alufn` 4'h2 and 4'h3), stalls the pipeline, and borrows the shared ALU for iterative shift-add and restoring division. It returns the result through the EX result mux. All other operations pass straight through to the ALU at zero latency.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: EX-stage kill (branch or exception); aborts any operation.
- `ex_valid`, input, 1: EX holds a valid instruction.
- `ex_alufn`, input, 4: decoded alufn from the control logic.
- `ex_a`, input, WIDTH: EX operand A.
- `ex_b`, input, WIDTH: EX operand B, already selected through bsel.
- `alu_a`, output, WIDTH: operand A to the shared ALU.
- `alu_b`, output, WIDTH: operand B to the shared ALU.
- `alu_fn`, output, 4: function code to the shared ALU.
- `alu_y`, input, WIDTH: shared ALU result.
- `stall`, output, 1: freeze IF/ID/EX this cycle.
- `ex_y`, output, WIDTH: EX result to the pipeline register.
- `res_valid`, output, 1: `ex_y` carries a MUL/DIV result this cycle.

## Operation
Signal definitions:
- `md_req = ex_valid & ~flush & (ex_alufn == MUL | ex_alufn == DIV)`.
- FSM states: IDLE, NEGA, NEGB, ITER, NEGQ, DONE. Reset state is IDLE.
- Registers: `acc`/R (WIDTH), `mcand`/D (WIDTH), `mplier`/Q (WIDTH), `cnt` (log2 WIDTH + 1 bits), `op`, `qneg`.

Datapath muxing:
- IDLE and DONE: `alu_a = ex_a`, `alu_b = ex_b`, `alu_fn = ex_alufn`.
- All other states: the ALU is driven by the sequencer only.
- `ex_y = res_valid ? res : alu_y`.

Transitions and per-state behaviour:
- **IDLE, MUL requested:** capture `acc = 0`, `mcand = ex_a`, `mplier = ex_b`, `cnt = WIDTH`. Go to ITER.
- **IDLE, DIV with `ex_b == 0`:** `res = {WIDTH{1}}`. Go to DONE.
- **IDLE, DIV otherwise:** capture `a`, `b`, `qneg = a[W-1] ^ b[W-1]`, R = 0. Go to NEGA.
- **NEGA:** ALU computes 0 − a (SUB, `alu_a = 0`). Q = `a[W-1]` ? `alu_y` : a.
- **NEGB:** same operation on b into D. Set `cnt = WIDTH`. Go to ITER.
- **ITER, MUL:** ALU computes ADD `acc + mcand`.
  - `acc` takes `alu_y` if `mplier[0]`, else holds.
  - `mcand <<= 1`, `mplier >>= 1`.
- **ITER, DIV:** form `R' = {R[W-2:0], Q[W-1]}`. ALU computes SUB `R' − D`.
  - `ge = (R' >= D)`, an internal unsigned comparator.
  - R takes `alu_y` if `ge`, else R'.
  - `Q = {Q[W-2:0], ge}`.
  - `R'` never overflows WIDTH because |D| ≤ 2^(W−1).
- **ITER exit:** `cnt` decrements each cycle. When it reaches 0, MUL goes to DONE with `res = acc`, and DIV goes to NEGQ.
- **NEGQ:** ALU computes 0 − Q. `res = qneg ? alu_y : Q`. Go to DONE.
- **DONE:** lasts exactly one cycle. `res_valid = 1`, `stall = 0`; the pipeline must advance. Go to IDLE.

Results and outputs:
- MUL returns the low WIDTH bits of the product, valid for signed and unsigned operands.
- DIV is signed and truncates toward zero. Divide-by-zero returns all ones and does not trap.
- `stall = (state == IDLE & md_req) | (state ∉ {IDLE, DONE})`.
- `flush` in any state returns the FSM to IDLE on the next edge. No `res_valid` is produced, and `stall` drops combinationally in the flush cycle.
- While `rst_n` is low: FSM = IDLE, all registers = 0, `res_valid = 0`. Outputs follow the IDLE pass-through.

## Timing
- Cycle 0 is the first cycle `md_req` is seen in IDLE.
- MUL: ITER occupies cycles 1..WIDTH. DONE at cycle WIDTH+1 (33 for WIDTH = 32). `stall` is high on cycles 0..WIDTH.
- DIV: NEGA at cycle 1, NEGB at 2, ITER at 3..WIDTH+2, NEGQ at WIDTH+3, DONE at WIDTH+4 (36). `stall` is high on cycles 0..WIDTH+3.
- DIV by zero: DONE at cycle 1.
- Non-MUL/DIV operations: zero added latency, `stall = 0`.
- Latency is fixed and data independent; there is no early termination.

## Structure
- Shared package `alu_pkg` holds:
  - ALUFN constants: ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, DIV = 4'h3.
  - The FSM state encoding.
  - The WIDTH default.
- Implemented as a single module; no sub-module is warranted. The shared ALU itself stays outside.

## Test plan
- **Pass-through:** ADD, `ex_a = 3`, `ex_b = 4` → `alu_*` mirror `ex_*`, `ex_y = 7`, `stall = 0`, `res_valid = 0`.
- **MUL basic and wrap:** 7 × 6 → `res_valid` at cycle 33 with `ex_y = 42`, `stall` high on cycles 0..32. Then 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- **Signed DIV:** −7 / 2 → 0xFFFFFFFD at cycle 36. 7 / −2 → 0xFFFFFFFD. 100 / 7 → 14.
- **DIV corners:** 0x80000000 / 0xFFFFFFFF → 0x80000000. 5 / 0 → 0xFFFFFFFF with `res_valid` at cycle 1.
- **Flush:** `flush` asserted at ITER cycle 10 of a MUL → IDLE next edge, no `res_valid`, `stall` low. A following 3 × 5 MUL → 15 at cycle 33.
- **Reset mid-operation:** `rst_n` low during DIV ITER → `stall` and `res_valid` drop immediately with no clock edge. After release, the FSM is in IDLE and a fresh DIV 9 / 3 → 3.
